// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined: registered ID-stage decoder for the RV32IM pipeline.
// Decodes one instruction per accepted cycle into ID/EX control fields, flags
// illegal encodings and holds issue while a multi-cycle MUL/DIV occupies EX.
module control_unit_pipelined #(
    parameter int ENABLE_M   = 1,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 34
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTRUCTION,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic        STALL,
    input  logic        FLUSH,
    output logic        OP1SEL,
    output logic        OP2SEL,
    output logic        REG_WRITE_EN,
    output logic [1:0]  WB_SEL,
    output logic [4:0]  ALUOP,
    output logic [2:0]  BRANCH_JUMP,
    output logic [2:0]  IMM_SEL,
    output logic [3:0]  READ_WRITE,
    output logic [4:0]  RS1_ADDR,
    output logic [4:0]  RS2_ADDR,
    output logic [4:0]  RD_ADDR,
    output logic        OUT_VALID,
    output logic        ILLEGAL,
    output logic        MC_START,
    output logic        MC_BUSY,
    output logic        MC_ABORT
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic {IDLE, MULTI} state_t;

    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       reg_write_en;
        logic [1:0] wb_sel;
        logic [4:0] aluop;
        logic [2:0] branch_jump;
        logic [2:0] imm_sel;
        logic [3:0] read_write;
        logic [4:0] rs1_addr;
        logic [4:0] rs2_addr;
        logic [4:0] rd_addr;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t nop_ctrl();
        ctrl_t c;
        c             = '0;
        c.branch_jump = 3'b010;
        return c;
    endfunction

    state_t          state;
    logic [CW-1:0]   count;
    ctrl_t           held;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    ctrl_t           dec;
    ctrl_t           issue;
    logic            dec_legal;
    logic            dec_mop;
    logic            dec_regs;
    logic            mc_needed;
    logic [CW-1:0]   mc_count;

    assign opcode = INSTRUCTION[6:0];
    assign funct3 = INSTRUCTION[14:12];
    assign funct7 = INSTRUCTION[31:25];

    assign IN_READY = !STALL && (state == IDLE);

    // Decode the incoming word into control fields and select what an IDLE cycle loads.
    always_comb begin
        dec       = nop_ctrl();
        dec_legal = 1'b1;
        dec_mop   = 1'b0;
        dec_regs  = 1'b1;
        case (opcode)
            OPC_LUI: begin
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_sel       = 2'b10;
            end
            OPC_AUIPC: begin
                dec.op1sel       = 1'b1;
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
            end
            OPC_JAL: begin
                dec.op1sel       = 1'b1;
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_sel       = 2'b11;
                dec.branch_jump  = 3'b011;
                dec.imm_sel      = 3'b001;
            end
            OPC_JALR: begin
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_sel       = 2'b11;
                dec.branch_jump  = 3'b011;
                dec.imm_sel      = 3'b100;
            end
            OPC_BRANCH: begin
                dec.op1sel      = 1'b1;
                dec.op2sel      = 1'b1;
                dec.branch_jump = funct3;
                dec.imm_sel     = 3'b011;
                dec_legal       = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                dec.wb_sel       = 2'b01;
                dec.imm_sel      = 3'b100;
                dec.read_write   = {1'b1, funct3};
                dec_legal        = (funct3 != 3'b011) && (funct3[2:1] != 2'b11);
            end
            OPC_STORE: begin
                dec.op2sel  = 1'b1;
                dec.imm_sel = 3'b010;
                case (funct3)
                    3'b000:  dec.read_write = 4'b1011;
                    3'b001:  dec.read_write = 4'b1110;
                    default: dec.read_write = 4'b1111;
                endcase
                dec_legal = (funct3 < 3'b011);
            end
            OPC_OPIMM: begin
                dec.op2sel       = 1'b1;
                dec.reg_write_en = 1'b1;
                if (funct3[1:0] == 2'b01) begin
                    dec.imm_sel = 3'b101;
                    dec.aluop   = {funct3, funct7[5], funct7[0]};
                    dec_legal   = funct3[2] ? ((funct7 == 7'b0000000) || (funct7 == 7'b0100000))
                                            : (funct7 == 7'b0000000);
                end else begin
                    dec.imm_sel = (funct3 == 3'b011) ? 3'b111 : 3'b100;
                    dec.aluop   = {funct3, 2'b00};
                end
            end
            OPC_OP: begin
                dec.reg_write_en = 1'b1;
                dec.aluop        = {funct3, funct7[5], funct7[0]};
                case (funct7)
                    7'b0000000: dec_legal = 1'b1;
                    7'b0100000: dec_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                    7'b0000001: begin
                        dec_legal = (ENABLE_M != 0);
                        dec_mop   = (ENABLE_M != 0);
                    end
                    default:    dec_legal = 1'b0;
                endcase
            end
            OPC_FENCE: dec_regs = 1'b0;
            default:   dec_legal = 1'b0;
        endcase

        if (dec_regs) begin
            dec.rs1_addr = INSTRUCTION[19:15];
            dec.rs2_addr = INSTRUCTION[24:20];
            dec.rd_addr  = INSTRUCTION[11:7];
        end

        issue = nop_ctrl();
        if (IN_VALID) begin
            if (dec_legal) begin
                issue = dec;
            end else begin
                issue.illegal = 1'b1;
            end
        end
    end

    // An M-op needs the MULTI sequence only when its EX latency exceeds one cycle.
    always_comb begin
        mc_needed = dec_mop && (funct3[2] ? (DIV_CYCLES > 1) : (MUL_CYCLES > 1));
        mc_count  = funct3[2] ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
    end

    // Issue state machine: FLUSH beats STALL, STALL freezes everything, otherwise
    // IDLE loads a freshly decoded op (or NOP) and MULTI counts the M-op down.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            count     <= '0;
            held      <= nop_ctrl();
            OUT_VALID <= 1'b0;
            MC_START  <= 1'b0;
            MC_BUSY   <= 1'b0;
            MC_ABORT  <= 1'b0;
        end else if (FLUSH) begin
            MC_ABORT  <= (state == MULTI);
            state     <= IDLE;
            count     <= '0;
            held      <= nop_ctrl();
            OUT_VALID <= 1'b0;
            MC_START  <= 1'b0;
            MC_BUSY   <= 1'b0;
        end else if (!STALL) begin
            MC_START <= 1'b0;
            MC_ABORT <= 1'b0;
            case (state)
                IDLE: begin
                    held <= issue;
                    if (IN_VALID && mc_needed) begin
                        state     <= MULTI;
                        count     <= mc_count;
                        MC_START  <= 1'b1;
                        MC_BUSY   <= 1'b1;
                        OUT_VALID <= 1'b0;
                    end else begin
                        OUT_VALID <= IN_VALID;
                    end
                end
                MULTI: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state     <= IDLE;
                        OUT_VALID <= 1'b1;
                        MC_BUSY   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign OP1SEL       = held.op1sel;
    assign OP2SEL       = held.op2sel;
    assign REG_WRITE_EN = held.reg_write_en;
    assign WB_SEL       = held.wb_sel;
    assign ALUOP        = held.aluop;
    assign BRANCH_JUMP  = held.branch_jump;
    assign IMM_SEL      = held.imm_sel;
    assign READ_WRITE   = held.read_write;
    assign RS1_ADDR     = held.rs1_addr;
    assign RS2_ADDR     = held.rs2_addr;
    assign RD_ADDR      = held.rd_addr;
    assign ILLEGAL      = held.illegal;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// tb_control_unit_pipelined: three decoder instances (default, M disabled,
// single-cycle MUL / 3-cycle DIV) driven by shared stimulus and compared each
// cycle against a behavioural model.
module tb_control_unit_pipelined;

    typedef struct packed {
        logic       op1sel;
        logic       op2sel;
        logic       rwe;
        logic [1:0] wb;
        logic [4:0] alu;
        logic [2:0] bj;
        logic [2:0] imm;
        logic [3:0] rw;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       ov;
        logic       ill;
        logic       start;
        logic       busy;
        logic       abort;
    } outs_t;

    localparam logic [31:0] DIV_W  = 32'h0220C1B3;
    localparam logic [31:0] MUL_W  = 32'h022081B3;
    localparam logic [31:0] ADDI_W = 32'h00500093;
    localparam logic [31:0] NOP_W  = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        in_valid;
    logic        stall;
    logic        flush;

    outs_t       obs [3];
    logic        rdy [3];

    outs_t       exp_o [3];
    int          busy_left [3];

    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       op1sel, op2sel, rwe, ov, ill, start, busy, abort, ready;
        logic [1:0] wb;
        logic [4:0] alu, rs1, rs2, rd;
        logic [2:0] bj, imm;
        logic [3:0] rw;

        control_unit_pipelined #(
            .ENABLE_M  ((g == 1) ? 0 : 1),
            .MUL_CYCLES((g == 2) ? 1 : 2),
            .DIV_CYCLES((g == 2) ? 3 : 34)
        ) u_dut (
            .CLK         (clk),
            .RESET_N     (rst_n),
            .INSTRUCTION (instr),
            .IN_VALID    (in_valid),
            .IN_READY    (ready),
            .STALL       (stall),
            .FLUSH       (flush),
            .OP1SEL      (op1sel),
            .OP2SEL      (op2sel),
            .REG_WRITE_EN(rwe),
            .WB_SEL      (wb),
            .ALUOP       (alu),
            .BRANCH_JUMP (bj),
            .IMM_SEL     (imm),
            .READ_WRITE  (rw),
            .RS1_ADDR    (rs1),
            .RS2_ADDR    (rs2),
            .RD_ADDR     (rd),
            .OUT_VALID   (ov),
            .ILLEGAL     (ill),
            .MC_START    (start),
            .MC_BUSY     (busy),
            .MC_ABORT    (abort)
        );

        assign obs[g] = {op1sel, op2sel, rwe, wb, alu, bj, imm, rw, rs1, rs2, rd,
                         ov, ill, start, busy, abort};
        assign rdy[g] = ready;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic outs_t nop_outs();
        outs_t o;
        o    = '0;
        o.bj = 3'b010;
        return o;
    endfunction

    function automatic int n_cycles(input int inst, input logic is_div);
        if (inst == 2) return is_div ? 3 : 1;
        return is_div ? 34 : 2;
    endfunction

    // Reference decode of one instruction word, straight from the encoding tables.
    function automatic outs_t ref_decode(input logic [31:0] w, input bit m_en, output bit is_m);
        outs_t      o;
        bit         ok;
        logic [2:0] f3;
        logic [6:0] f7;
        f3   = w[14:12];
        f7   = w[31:25];
        o    = nop_outs();
        ok   = 1'b1;
        is_m = 1'b0;
        case (w[6:0])
            7'b0110111: begin o.op2sel = 1; o.rwe = 1; o.wb = 2'b10; end
            7'b0010111: begin o.op1sel = 1; o.op2sel = 1; o.rwe = 1; end
            7'b1101111: begin o.op1sel = 1; o.op2sel = 1; o.rwe = 1; o.wb = 2'b11; o.bj = 3'b011; o.imm = 3'b001; end
            7'b1100111: begin o.op2sel = 1; o.rwe = 1; o.wb = 2'b11; o.bj = 3'b011; o.imm = 3'b100; end
            7'b1100011: begin
                o.op1sel = 1; o.op2sel = 1; o.bj = f3; o.imm = 3'b011;
                ok = !(f3 == 3'd2 || f3 == 3'd3);
            end
            7'b0000011: begin
                o.op2sel = 1; o.rwe = 1; o.wb = 2'b01; o.imm = 3'b100;
                case (f3)
                    3'd0:    o.rw = 4'b1000;
                    3'd1:    o.rw = 4'b1001;
                    3'd2:    o.rw = 4'b1010;
                    3'd4:    o.rw = 4'b1100;
                    3'd5:    o.rw = 4'b1101;
                    default: ok = 1'b0;
                endcase
            end
            7'b0100011: begin
                o.op2sel = 1; o.imm = 3'b010;
                case (f3)
                    3'd0:    o.rw = 4'b1011;
                    3'd1:    o.rw = 4'b1110;
                    3'd2:    o.rw = 4'b1111;
                    default: ok = 1'b0;
                endcase
            end
            7'b0010011: begin
                o.op2sel = 1; o.rwe = 1;
                if (f3 == 3'd1) begin
                    o.imm = 3'b101; o.alu = {f3, f7[5], f7[0]}; ok = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    o.imm = 3'b101; o.alu = {f3, f7[5], f7[0]}; ok = (f7 == 7'h00) || (f7 == 7'h20);
                end else if (f3 == 3'd3) begin
                    o.imm = 3'b111; o.alu = {f3, 2'b00};
                end else begin
                    o.imm = 3'b100; o.alu = {f3, 2'b00};
                end
            end
            7'b0110011: begin
                o.rwe = 1; o.alu = {f3, f7[5], f7[0]};
                if (f7 == 7'h00)      ok = 1'b1;
                else if (f7 == 7'h20) ok = (f3 == 3'd0) || (f3 == 3'd5);
                else if (f7 == 7'h01) begin ok = m_en; is_m = m_en; end
                else                  ok = 1'b0;
            end
            7'b0001111: ;
            default:    ok = 1'b0;
        endcase
        if (ok && w[6:0] != 7'b0001111) begin
            o.rs1 = w[19:15];
            o.rs2 = w[24:20];
            o.rd  = w[11:7];
        end
        if (!ok) begin
            o     = nop_outs();
            o.ill = 1'b1;
            is_m  = 1'b0;
        end
        o.ov = 1'b1;
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_o[i]     = nop_outs();
            busy_left[i] = 0;
        end
    endtask

    // Advance every instance's model by one clock edge using the current inputs.
    task automatic model_edge();
        bit is_m;
        int n;
        for (int i = 0; i < 3; i++) begin
            if (flush) begin
                exp_o[i]       = nop_outs();
                exp_o[i].abort = (busy_left[i] > 0);
                busy_left[i]   = 0;
            end else if (!stall) begin
                if (busy_left[i] > 0) begin
                    busy_left[i]--;
                    exp_o[i].start = 1'b0;
                    exp_o[i].abort = 1'b0;
                    if (busy_left[i] == 0) begin
                        exp_o[i].ov   = 1'b1;
                        exp_o[i].busy = 1'b0;
                    end
                end else if (in_valid) begin
                    exp_o[i] = ref_decode(instr, (i != 1), is_m);
                    n = n_cycles(i, instr[14]);
                    if (is_m && n > 1) begin
                        exp_o[i].ov    = 1'b0;
                        exp_o[i].start = 1'b1;
                        exp_o[i].busy  = 1'b1;
                        busy_left[i]   = n - 1;
                    end
                end else begin
                    exp_o[i] = nop_outs();
                end
            end
        end
    endtask

    // One clock: drive at the falling edge, check IN_READY, clock, check registered outputs.
    task automatic step(input logic [31:0] w, input bit v, input bit s, input bit f);
        instr    = w;
        in_valid = v;
        stall    = s;
        flush    = f;
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("ready_d%0d", i), rdy[i], (!s && busy_left[i] == 0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("outs_d%0d", i), obs[i], exp_o[i]);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_d%0d", i), obs[i], exp_o[i]);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_div(input int st_from, input int st_len, output int lat, output int busy_n);
        bit done;
        lat    = -1;
        busy_n = 0;
        done   = 1'b0;
        step(DIV_W, 1, 0, 0);
        check("div_start", obs[0].start, 1);
        if (obs[0].busy) busy_n++;
        for (int c = 2; c <= 80 && !done; c++) begin
            step(NOP_W, 1, (c >= st_from && c < st_from + st_len), 0);
            if (obs[0].busy) busy_n++;
            if (obs[0].ov) begin
                lat  = c;
                done = 1'b1;
            end
        end
        check("div_alu", obs[0].alu, 5'b10001);
        check("div_rd", obs[0].rd, 5'd3);
        check("div_busy_end", obs[0].busy, 0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0:       w[6:0] = 7'b0110111;
            1:       w[6:0] = 7'b0010111;
            2:       w[6:0] = 7'b1101111;
            3:       w[6:0] = 7'b1100111;
            4:       w[6:0] = 7'b1100011;
            5:       w[6:0] = 7'b0000011;
            6:       w[6:0] = 7'b0100011;
            7:       w[6:0] = 7'b0010011;
            8:       w[6:0] = 7'b0110011;
            9:       w[6:0] = 7'b0001111;
            10:      w[6:0] = 7'b1110011;
            default: ;
        endcase
        if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) begin
            case ($urandom_range(0, 3))
                0:       w[31:25] = 7'b0000000;
                1:       w[31:25] = 7'b0100000;
                2:       w[31:25] = 7'b0000001;
                default: ;
            endcase
        end
        return w;
    endfunction

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_n;
        rst_n    = 1'b0;
        instr    = '0;
        in_valid = 1'b0;
        stall    = 1'b0;
        flush    = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();
        check("rst_bj", obs[0].bj, 3'b010);
        check("rst_ov", obs[0].ov, 0);

        step(ADDI_W, 1, 0, 0);
        check("addi_ov", obs[0].ov, 1);
        check("addi_op2", obs[0].op2sel, 1);
        check("addi_imm", obs[0].imm, 3'b100);
        check("addi_rwe", obs[0].rwe, 1);
        check("addi_wb", obs[0].wb, 2'b00);
        check("addi_alu", obs[0].alu, 5'b00000);
        check("addi_rd", obs[0].rd, 5'd1);

        step(32'h0020A423, 1, 0, 0);
        check("sw_rw", obs[0].rw, 4'b1111);
        check("sw_imm", obs[0].imm, 3'b010);
        check("sw_rwe", obs[0].rwe, 0);

        step(32'h0020E463, 1, 0, 0);
        check("bltu_bj", obs[0].bj, 3'b110);
        check("bltu_op1", obs[0].op1sel, 1);
        check("bltu_imm", obs[0].imm, 3'b011);

        step(32'h010000EF, 1, 0, 0);
        check("jal_bj", obs[0].bj, 3'b011);
        check("jal_wb", obs[0].wb, 2'b11);

        step(NOP_W, 0, 0, 0);
        check("idle_ov", obs[0].ov, 0);

        run_div(0, 0, lat, busy_n);
        check("div_latency", lat, 34);
        check("div_busy_cycles", busy_n, 33);
        step(NOP_W, 0, 0, 0);

        run_div(10, 5, lat, busy_n);
        check("div_stall_latency", lat, 39);
        check("div_stall_busy", busy_n, 38);
        step(NOP_W, 0, 0, 0);

        step(DIV_W, 1, 0, 0);
        for (int k = 0; k < 8; k++) step(NOP_W, 0, 0, 0);
        step(NOP_W, 1, 0, 1);
        check("flush_abort", obs[0].abort, 1);
        check("flush_ov", obs[0].ov, 0);
        check("flush_busy", obs[0].busy, 0);
        check("flush_ready", rdy[0], 1);
        step(NOP_W, 0, 0, 0);
        check("flush_abort_pulse", obs[0].abort, 0);

        step(32'h00000073, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sys_ill_d%0d", i), obs[i].ill, 1);
            check($sformatf("sys_ov_d%0d", i), obs[i].ov, 1);
            check($sformatf("sys_rwe_d%0d", i), obs[i].rwe, 0);
            check($sformatf("sys_rw_d%0d", i), obs[i].rw, 4'b0000);
        end

        step(MUL_W, 1, 0, 0);
        check("mul_noM_ill", obs[1].ill, 1);
        check("mul_noM_ov", obs[1].ov, 1);
        check("mul_n1_ov", obs[2].ov, 1);
        check("mul_n1_start", obs[2].start, 0);
        check("mul_n1_alu", obs[2].alu, 5'b00001);
        check("mul_n2_start", obs[0].start, 1);
        step(NOP_W, 0, 0, 0);
        check("mul_n2_done", obs[0].ov, 1);

        step(DIV_W, 1, 0, 0);
        for (int k = 0; k < 3; k++) step(NOP_W, 0, 0, 0);
        do_reset();
        check("rstmid_busy", obs[0].busy, 0);
        check("rstmid_abort", obs[0].abort, 0);
        check("rstmid_ready", rdy[0], 1);

        for (int k = 0; k < 2000; k++)
            step(rand_instr(), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 19) == 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
